// File: rtl/jpeg_rle_dezigzag_dec.sv
// JPEG decoder-side run-length expansion and de-zigzag: rebuilds one 8x8 block of
// coefficients from (run, amplitude) symbols, then streams it out in raster order.
module jpeg_rle_dezigzag_dec #(
   parameter int COEF_W = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_run,
   input  logic signed [COEF_W-1:0] in_amp,
   input  logic                     in_eob,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [COEF_W-1:0] out_coef,
   output logic [5:0]               out_idx,
   output logic                     out_last,
   output logic                     err
);

   typedef enum logic [1:0] {
      FILL_DC,
      FILL_AC,
      DRAIN
   } state_e;

   // Zigzag position -> natural (row-major) index.
   localparam logic [5:0] ZZ_TAB [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   state_e                   state_q, state_d;
   logic [5:0]               k_q, k_d;
   logic [5:0]               r_q, r_d;
   logic [63:0]              mask_q, mask_d;
   logic                     in_ready_q;
   logic                     err_q, err_d;
   logic                     wr_en;
   logic [5:0]               wr_idx;
   logic [6:0]               nk;
   logic                     accept;
   logic signed [COEF_W-1:0] buf_q [64];

   assign accept = in_valid && in_ready_q;
   assign nk     = {1'b0, k_q} + {3'b000, in_run} + 7'd1;

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      r_d     = r_q;
      mask_d  = mask_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = 6'd0;
      case (state_q)
         FILL_DC: begin
            if (accept) begin
               if (in_eob) begin
                  state_d = DRAIN;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = 6'd0;
                  k_d     = 6'd0;
                  state_d = FILL_AC;
               end
            end
         end
         FILL_AC: begin
            if (accept) begin
               if (in_eob) begin
                  state_d = DRAIN;
               end else if (nk > 7'd63) begin
                  // Run overflows the block: drop the symbol and close the block.
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = ZZ_TAB[nk[5:0]];
                  k_d    = nk[5:0];
                  if (nk == 7'd63) state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               r_d = r_q + 6'd1;
               if (r_q == 6'd63) begin
                  mask_d  = '0;
                  state_d = FILL_DC;
               end
            end
         end
         default: state_d = FILL_DC;
      endcase
      if (wr_en) mask_d[wr_idx] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL_DC;
         k_q        <= 6'd0;
         r_q        <= 6'd0;
         mask_q     <= '0;
         in_ready_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         r_q        <= r_d;
         mask_q     <= mask_d;
         in_ready_q <= (state_d != DRAIN);
         err_q      <= err_d;
      end
   end

   // NOTE: the coefficient buffer is deliberately not reset; the written-mask
   // hides stale contents, so only the mask needs clearing.
   always_ff @(posedge clk) begin
      if (wr_en) buf_q[wr_idx] <= in_amp;
   end

   assign in_ready  = in_ready_q;
   assign err       = err_q;
   assign out_valid = (state_q == DRAIN);
   assign out_idx   = out_valid ? r_q : 6'd0;
   assign out_last  = out_valid && (r_q == 6'd63);
   assign out_coef  = (out_valid && mask_q[r_q]) ? buf_q[r_q] : '0;

endmodule

// File: tb/tb_jpeg_rle_dezigzag_dec.sv
// Directed bench for jpeg_rle_dezigzag_dec: each block's expected raster output is
// written by hand and compared coefficient by coefficient after draining.
module tb_jpeg_rle_dezigzag_dec;

   localparam int COEF_W = 12;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [3:0]               in_run;
   logic signed [COEF_W-1:0] in_amp;
   logic                     in_eob;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [COEF_W-1:0] out_coef;
   logic [5:0]               out_idx;
   logic                     out_last;
   logic                     err;

   int n_checks = 0;
   int n_fails  = 0;
   int err_cycles = 0;
   int drain_cycles;
   int e0;
   logic signed [31:0] expv [64];
   logic signed [31:0] got  [64];

   jpeg_rle_dezigzag_dec #(.COEF_W(COEF_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_run(in_run),
      .in_amp(in_amp), .in_eob(in_eob),
      .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
      .out_idx(out_idx), .out_last(out_last), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (err === 1'b1) err_cycles++;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 64; i++) expv[i] = 0;
   endtask

   task automatic send(input logic [3:0] run, input int amp, input logic eob);
      int wait_cyc = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_run   = run;
      in_amp   = amp[COEF_W-1:0];
      in_eob   = eob;
      while (in_ready !== 1'b1 && wait_cyc < 200) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (wait_cyc >= 200) check("send_timeout", wait_cyc, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain(input int upto, input bit stall);
      int cnt = 0;
      int cyc = 0;
      bit held = 1'b0;
      logic [3:0] pat = 4'b1001;
      logic signed [COEF_W-1:0] hc;
      logic [5:0] hi;
      while (cnt < upto && cyc < 400) begin
         @(negedge clk);
         if (cyc == 0) check("first_valid", out_valid, 1);
         if (held) begin
            check($sformatf("hold_coef%0d", cnt), out_coef, hc);
            check($sformatf("hold_idx%0d", cnt), out_idx, hi);
         end
         out_ready = stall ? pat[cyc % 4] : 1'b1;
         held = 1'b0;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               check($sformatf("idx%0d", cnt), out_idx, cnt);
               check($sformatf("last%0d", cnt), out_last, (cnt == 63));
               got[cnt] = out_coef;
               cnt++;
            end else begin
               held = 1'b1;
               hc   = out_coef;
               hi   = out_idx;
            end
         end
         cyc++;
      end
      if (cnt < upto) check("drain_timeout", cnt, upto);
      drain_cycles = cyc;
      out_ready = 1'b1;
   endtask

   task automatic compare_block(input string blk, input int upto);
      for (int i = 0; i < upto; i++)
         check($sformatf("%s_coef%0d", blk, i), got[i], expv[i]);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_run    = '0;
      in_amp    = '0;
      in_eob    = 1'b0;
      out_ready = 1'b1;
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_coef", out_coef, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);

      // DC-only block
      e0 = err_cycles;
      clear_exp();
      expv[0] = 100;
      send(4'd0, 100, 1'b0);
      send(4'd0, 0, 1'b1);
      drain(64, 1'b0);
      check("t1_drain_cycles", drain_cycles, 64);
      compare_block("t1", 64);
      @(negedge clk);
      check("t1_err", err_cycles - e0, 0);
      check("t1_in_ready_back", in_ready, 1);

      // DC plus three AC symbols
      clear_exp();
      expv[0] = 5; expv[1] = -3; expv[8] = 7; expv[9] = 2;
      send(4'd0, 5, 1'b0);
      send(4'd0, -3, 1'b0);
      send(4'd0, 7, 1'b0);
      send(4'd1, 2, 1'b0);
      send(4'd0, 0, 1'b1);
      drain(64, 1'b0);
      compare_block("t2", 64);

      // ZRL x3 then run 14 lands exactly on position 63: no EOB needed
      clear_exp();
      expv[63] = 1;
      send(4'd0, 0, 1'b0);
      send(4'd15, 0, 1'b0);
      send(4'd15, 0, 1'b0);
      send(4'd15, 0, 1'b0);
      send(4'd14, 1, 1'b0);
      drain(64, 1'b0);
      compare_block("t3", 64);

      // run overflow past 63: err pulses once, amplitude dropped
      e0 = err_cycles;
      clear_exp();
      expv[0] = 1;
      send(4'd0, 1, 1'b0);
      send(4'd15, 0, 1'b0);
      send(4'd15, 0, 1'b0);
      send(4'd15, 0, 1'b0);
      send(4'd15, 9, 1'b0);
      drain(64, 1'b0);
      compare_block("t4", 64);
      check("t4_err_cycles", err_cycles - e0, 1);

      // back-to-back blocks with a stalling consumer
      clear_exp();
      expv[0] = 3; expv[8] = -2;
      send(4'd0, 3, 1'b0);
      send(4'd1, -2, 1'b0);
      send(4'd0, 0, 1'b1);
      drain(64, 1'b1);
      compare_block("t5a", 64);
      clear_exp();
      expv[0] = 4;
      send(4'd0, 4, 1'b0);
      send(4'd0, 0, 1'b1);
      drain(64, 1'b1);
      compare_block("t5b", 64);

      // reset in the middle of a drain
      clear_exp();
      expv[0] = 9; expv[1] = 3;
      send(4'd0, 9, 1'b0);
      send(4'd0, 3, 1'b0);
      send(4'd0, 0, 1'b1);
      drain(30, 1'b0);
      compare_block("t6pre", 30);
      @(negedge clk);
      check("t6_idx_before_rst", out_idx, 30);
      check("t6_valid_before_rst", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_coef", out_coef, 0);
      check("t6_rst_idx", out_idx, 0);
      check("t6_rst_last", out_last, 0);
      check("t6_rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      clear_exp();
      expv[0] = -7;
      send(4'd0, -7, 1'b0);
      send(4'd0, 0, 1'b1);
      drain(64, 1'b0);
      compare_block("t6", 64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
